// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES-128/192/256 forward cipher, one round per clock.
// Round keys arrive pre-expanded on iRoundKeys (RK0 in the MSBs) and must stay stable until oValid.
module aes_cipher_iter #(
   parameter int  KEY_SIZE = 128,
   localparam int NR       = (KEY_SIZE == 256) ? 14 : (KEY_SIZE == 192) ? 12 : 10
) (
   input  logic                  iClk,
   input  logic                  iRst,
   input  logic                  iStart,
   input  logic [127:0]          iBlock,
   input  logic [(NR+1)*128-1:0] iRoundKeys,
   output logic [127:0]          oBlock,
   output logic                  oValid,
   output logic                  oBusy
);
   localparam logic [3:0] NR4 = 4'(NR);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] st_q, st_d, out_q, out_d;
   logic [127:0] sb, sr, mc, rk_cur;
   logic [127:0] rk [16];
   logic         last;

   if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad
      $error("aes_cipher_iter: KEY_SIZE must be 128, 192 or 256");
   end

   // Unused slots above NR read as zero so the 4-bit round index never selects out of range.
   for (genvar g = 0; g < 16; g++) begin : g_rk
      if (g <= NR) begin : g_on
         assign rk[g] = iRoundKeys[(NR+1)*128-1-128*g -: 128];
      end else begin : g_off
         assign rk[g] = '0;
      end
   end

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[11'd2047 - {x, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   // Byte k sits at row k%4, column k/4; ShiftRows rotates row r left by r columns.
   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      for (int k = 0; k < 16; k++) sb[127-8*k -: 8] = sbox(st_q[127-8*k -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      for (int c = 0; c < 4; c++) mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
   end

   assign rk_cur = rk[rnd_q];
   assign last   = rnd_q == NR4;

   always_comb begin
      fsm_d = fsm_q;
      rnd_d = rnd_q;
      st_d  = st_q;
      out_d = out_q;
      if (fsm_q == ROUND) begin
         st_d  = (last ? sr : mc) ^ rk_cur;
         fsm_d = last ? DONE : ROUND;
         rnd_d = last ? 4'd0 : rnd_q + 4'd1;
         out_d = last ? sr ^ rk_cur : out_q;
      end else if (iStart) begin
         fsm_d = ROUND;
         rnd_d = 4'd1;
         st_d  = iBlock ^ rk[0];
      end else begin
         fsm_d = IDLE;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         fsm_q <= IDLE;
         rnd_q <= '0;
         st_q  <= '0;
         out_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         rnd_q <= rnd_d;
         st_q  <= st_d;
         out_q <= out_d;
      end
   end

   assign oBlock = out_q;
   assign oValid = fsm_q == DONE;
   assign oBusy  = fsm_q == ROUND;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: FIPS-197 vectors through 128/192/256-bit instances; round keys from a
// bench-side key expansion whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_cipher_iter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, s128, s192, s256;
   logic [127:0]  blk;
   logic [1407:0] rk128;
   logic [1663:0] rk192;
   logic [1919:0] rk256;
   logic [127:0]  o128, o192, o256;
   logic          v128, v192, v256, b128, b192, b256;

   aes_cipher_iter #(.KEY_SIZE(128)) d128 (.iClk(clk), .iRst(rst), .iStart(s128), .iBlock(blk),
      .iRoundKeys(rk128), .oBlock(o128), .oValid(v128), .oBusy(b128));
   aes_cipher_iter #(.KEY_SIZE(192)) d192 (.iClk(clk), .iRst(rst), .iStart(s192), .iBlock(blk),
      .iRoundKeys(rk192), .oBlock(o192), .oValid(v192), .oBusy(b192));
   aes_cipher_iter #(.KEY_SIZE(256)) d256 (.iClk(clk), .iRst(rst), .iStart(s256), .iBlock(blk),
      .iRoundKeys(rk256), .oBlock(o256), .oValid(v256), .oBusy(b256));

   typedef struct {
      int           ks;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t       vt [4];
   logic [7:0] sb_t [256];
   int         n_tests = 0;
   int         n_fail = 0;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rl(input logic [7:0] v, input int n);
      return 8'((v << n) | (v >> (8 - n)));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
   endfunction

   function automatic logic [1919:0] kexp(input logic [255:0] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [1919:0] r = '0;
      for (int i = 0; i < 4 * (nk + 7); i++) begin
         if (i < nk) w[i] = key[255-32*i -: 32];
         else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
         end
         r[1919-32*i -: 32] = w[i];
      end
      return r;
   endfunction

   task automatic load_key(input int ks, input logic [255:0] key);
      logic [1919:0] r;
      r = kexp(key, ks / 32);
      if (ks == 128) rk128 = r[1919 -: 1408];
      else if (ks == 192) rk192 = r[1919 -: 1664];
      else rk256 = r;
   endtask

   function automatic logic get_v(input int ks);
      return ks == 128 ? v128 : ks == 192 ? v192 : v256;
   endfunction

   function automatic logic get_b(input int ks);
      return ks == 128 ? b128 : ks == 192 ? b192 : b256;
   endfunction

   function automatic logic [127:0] get_o(input int ks);
      return ks == 128 ? o128 : ks == 192 ? o192 : o256;
   endfunction

   task automatic set_start(input int ks, input logic v);
      if (ks == 128) s128 = v;
      else if (ks == 192) s192 = v;
      else s256 = v;
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic run_one(input int idx);
      int           ks, nr, lat, busy_n, pulses;
      logic [127:0] got;
      ks = vt[idx].ks;
      nr = ks / 32 + 6;
      lat = -1;
      busy_n = 0;
      pulses = 0;
      got = '0;
      load_key(ks, vt[idx].key);
      @(negedge clk);
      blk = vt[idx].pt;
      set_start(ks, 1'b1);
      chk($sformatf("v%0d idle busy", idx), 128'(get_b(ks)), 128'd0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1) begin
            set_start(ks, 1'b0);
            blk = {$urandom, $urandom, $urandom, $urandom};
         end
         if (get_b(ks)) busy_n++;
         if (get_v(ks)) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               got = get_o(ks);
            end
         end
      end
      chk($sformatf("v%0d latency", idx), 128'(lat), 128'(nr + 1));
      chk($sformatf("v%0d ciphertext", idx), got, vt[idx].ct);
      chk($sformatf("v%0d busy cycles", idx), 128'(busy_n), 128'(nr));
      chk($sformatf("v%0d valid pulses", idx), 128'(pulses), 128'd1);
      chk($sformatf("v%0d oBlock hold", idx), get_o(ks), vt[idx].ct);
   endtask

   initial begin
      int p1, p2, pulses;
      vt[0] = '{128, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vt[1] = '{128, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
      vt[2] = '{192, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
      vt[3] = '{256, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
      rst = 1'b1;
      s128 = 1'b0;
      s192 = 1'b0;
      s256 = 1'b0;
      blk = '0;
      build_sbox();
      load_key(128, vt[0].key);
      load_key(192, vt[2].key);
      load_key(256, vt[3].key);
      repeat (3) @(negedge clk);
      chk("reset oBlock128", o128, '0);
      chk("reset oBlock192", o192, '0);
      chk("reset oBlock256", o256, '0);
      chk("reset valid/busy", 128'({v128, v192, v256, b128, b192, b256}), 128'd0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) run_one(i);

      // Start held high across two blocks; new key/plaintext presented only in the oValid cycle.
      p1 = -1;
      p2 = -1;
      pulses = 0;
      load_key(128, vt[0].key);
      @(negedge clk);
      blk = vt[0].pt;
      s128 = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (v128) begin
            pulses++;
            if (pulses == 1) begin
               p1 = k;
               chk("b2b first ct", o128, vt[0].ct);
               chk("b2b busy in done", 128'(b128), 128'd0);
               blk = vt[1].pt;
               load_key(128, vt[1].key);
            end else begin
               p2 = k;
               chk("b2b second ct", o128, vt[1].ct);
            end
         end else blk = {$urandom, $urandom, $urandom, $urandom};
         if (k == 12) begin
            chk("b2b accepted in done", 128'(b128), 128'd1);
            s128 = 1'b0;
         end
      end
      chk("b2b first latency", 128'(p1), 128'd11);
      chk("b2b spacing", 128'(p2 - p1), 128'd11);
      chk("b2b pulses", 128'(pulses), 128'd2);

      // Reset in cycle 5 of an encryption aborts it without a result.
      load_key(128, vt[0].key);
      @(negedge clk);
      blk = vt[0].pt;
      s128 = 1'b1;
      @(negedge clk);
      s128 = 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort oBlock", o128, '0);
      chk("abort busy", 128'(b128), 128'd0);
      chk("abort valid", 128'(v128), 128'd0);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (v128) pulses++;
      end
      chk("abort no pulse", 128'(pulses), 128'd0);
      run_one(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
